scan_sequencer: RTL and testbench

Frame-level controller for the film scanner line pipeline: it sequences calibration lines, stepper-motor advances, mechanical settling, and CCD line captures. It sits above the CCD timing generator, whose `en` and `cal_mode` inputs it drives, and whose end-of-line pulse it consumes. One `start` pulse runs a whole frame; firmware only programs the configuration inputs.

---
 rtl/scan_seq_pkg.sv | 34 +++
 rtl/scan_sequencer_motor_step_gen.sv | 68 ++++++
 rtl/scan_sequencer.sv | 157 +++++++++++++++
 tb/tb_scan_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and sizing for the film scanner frame sequencer.
package scan_seq_pkg;

    localparam int STEP_W_DEFAULT       = 16;
    localparam int LINE_TIMEOUT_DEFAULT = 16_000_000;

    localparam int WAIT_CNT_W   = 24;
    localparam int STEP_CNT_W   = 8;
    localparam int SETTLE_CNT_W = 16;
    localparam int LINE_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE, CAL_WAIT, STEP_HI, STEP_LO, SETTLE, LINE_WAIT, DONE, FAULT
    } scan_state_t;

    typedef enum logic [1:0] {
        PH_IDLE, PH_HI, PH_LO
    } step_phase_t;

    // First non-empty phase of the per-line sequence. After a completed line
    // an otherwise empty sequence still spends one SETTLE cycle so line_en drops.
    function automatic scan_state_t line_entry(
        input logic [LINE_CNT_W-1:0]   num,
        input logic [STEP_CNT_W-1:0]   steps,
        input logic [SETTLE_CNT_W-1:0] settle,
        input logic                    after_line
    );
        if (num == '0)                       return DONE;
        else if (steps != '0)                return STEP_HI;
        else if (settle != '0 || after_line) return SETTLE;
        else                                 return LINE_WAIT;
    endfunction

endpackage

// File: rtl/scan_sequencer_motor_step_gen.sv
// Stepper pulse train: `count` pulses of STEP_W cycles high then STEP_W low.
module motor_step_gen
    import scan_seq_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input  logic                  clk_160M,
    input  logic                  rst,
    input  logic                  launch,
    input  logic                  abort,
    input  logic [STEP_CNT_W-1:0] count,
    output logic                  motor_step,
    output logic                  steps_done,
    output logic                  phase_end
);

    localparam int TW = (STEP_W > 1) ? $clog2(STEP_W) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(STEP_W - 1);

    step_phase_t           phase;
    logic [TW-1:0]         tmr;
    logic [STEP_CNT_W-1:0] steps_left;

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            phase      <= PH_IDLE;
            tmr        <= '0;
            steps_left <= '0;
        end else if (abort) begin
            phase <= PH_IDLE;
            tmr   <= '0;
        end else if (launch && count != '0) begin
            phase      <= PH_HI;
            tmr        <= TMR_LOAD;
            steps_left <= count;
        end else begin
            case (phase)
                PH_HI: begin
                    if (tmr == '0) begin
                        phase <= PH_LO;
                        tmr   <= TMR_LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                PH_LO: begin
                    if (tmr == '0) begin
                        tmr <= TMR_LOAD;
                        if (steps_left == 8'd1) begin
                            phase <= PH_IDLE;
                        end else begin
                            phase      <= PH_HI;
                            steps_left <= steps_left - 1'b1;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    assign motor_step = (phase == PH_HI);
    assign phase_end  = (phase != PH_IDLE) && (tmr == '0);
    assign steps_done = (phase == PH_LO) && (tmr == '0) && (steps_left == 8'd1);

endmodule

// File: rtl/scan_sequencer.sv
// Frame controller: calibration lines, motor advance, settle and capture per line.
//   state     | meaning
//   IDLE      | waiting for start
//   CAL_WAIT  | capturing calibration lines (cal_mode high)
//   STEP_HI   | motor step pulse high half
//   STEP_LO   | motor step pulse low half
//   SETTLE    | mechanical settle after last step
//   LINE_WAIT | capturing an image line
//   DONE      | one-cycle completion pulse
//   FAULT     | line_done timeout, error raised
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int STEP_W       = STEP_W_DEFAULT,
    parameter int LINE_TIMEOUT = LINE_TIMEOUT_DEFAULT
) (
    input  logic                    clk_160M,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LINE_CNT_W-1:0]   num_lines,
    input  logic [7:0]              cal_lines,
    input  logic [STEP_CNT_W-1:0]   steps_per_line,
    input  logic [SETTLE_CNT_W-1:0] settle_cycles,
    input  logic                    dir,
    input  logic                    line_done,
    output logic                    line_en,
    output logic                    cal_mode,
    output logic                    motor_step,
    output logic                    motor_dir,
    output logic [LINE_CNT_W-1:0]   line_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    scan_state_t             state, state_nxt;
    logic [LINE_CNT_W-1:0]   num_q, cfg_num;
    logic [STEP_CNT_W-1:0]   steps_q, cfg_steps;
    logic [SETTLE_CNT_W-1:0] settle_q, cfg_settle;
    logic [7:0]              cal_left;
    logic                    dir_q;
    logic [WAIT_CNT_W-1:0]   wait_tmr;
    logic [SETTLE_CNT_W-1:0] settle_tmr;
    logic                    line_gap;
    logic                    accept, launch, cal_ld, line_ld;
    logic                    steps_done, phase_end;

    motor_step_gen #(.STEP_W(STEP_W)) u_step_gen (
        .clk_160M   (clk_160M),
        .rst        (rst),
        .launch     (launch),
        .abort      (abort),
        .count      (cfg_steps),
        .motor_step (motor_step),
        .steps_done (steps_done),
        .phase_end  (phase_end)
    );

    always_comb begin
        // In IDLE the live inputs feed the first-phase decision on the start cycle.
        cfg_num    = (state == IDLE) ? num_lines      : num_q;
        cfg_steps  = (state == IDLE) ? steps_per_line : steps_q;
        cfg_settle = (state == IDLE) ? settle_cycles  : settle_q;
        cal_ld     = (state == CAL_WAIT) && line_done && !line_gap && !abort;
        line_ld    = (state == LINE_WAIT) && line_done && !abort;
        accept     = 1'b0;
        state_nxt  = state;
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        accept = 1'b1;
                        if (cal_lines != '0)      state_nxt = CAL_WAIT;
                        else if (num_lines == '0) state_nxt = SETTLE;
                        else state_nxt = line_entry(num_lines, steps_per_line, settle_cycles, 1'b0);
                    end
                end
                CAL_WAIT: begin
                    if (cal_ld) begin
                        if (cal_left == 8'd1)
                            state_nxt = line_entry(cfg_num, cfg_steps, cfg_settle, 1'b1);
                    end else if (wait_tmr == '0) begin
                        state_nxt = FAULT;
                    end
                end
                STEP_HI: if (phase_end) state_nxt = STEP_LO;
                STEP_LO: begin
                    if (steps_done)     state_nxt = (cfg_settle != '0) ? SETTLE : LINE_WAIT;
                    else if (phase_end) state_nxt = STEP_HI;
                end
                SETTLE: if (settle_tmr == '0) state_nxt = (cfg_num == '0) ? DONE : LINE_WAIT;
                LINE_WAIT: begin
                    if (line_ld) begin
                        if (line_idx + 16'd1 == cfg_num) state_nxt = DONE;
                        else state_nxt = line_entry(cfg_num, cfg_steps, cfg_settle, 1'b1);
                    end else if (wait_tmr == '0) begin
                        state_nxt = FAULT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        launch = (state_nxt == STEP_HI) && (state != STEP_HI) && (state != STEP_LO);
    end

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            state      <= IDLE;
            num_q      <= '0;
            steps_q    <= '0;
            settle_q   <= '0;
            cal_left   <= '0;
            dir_q      <= 1'b0;
            wait_tmr   <= '0;
            settle_tmr <= '0;
            line_gap   <= 1'b0;
            line_idx   <= '0;
            error      <= 1'b0;
        end else begin
            state    <= state_nxt;
            line_gap <= cal_ld && (state_nxt == CAL_WAIT);
            if (accept) begin
                num_q    <= num_lines;
                steps_q  <= steps_per_line;
                settle_q <= settle_cycles;
                cal_left <= cal_lines;
                dir_q    <= dir;
                line_idx <= '0;
                error    <= 1'b0;
            end else begin
                if (cal_ld)  cal_left <= cal_left - 1'b1;
                if (line_ld) line_idx <= line_idx + 1'b1;
            end
            if (state_nxt == FAULT) error <= 1'b1;

            if ((state_nxt == CAL_WAIT || state_nxt == LINE_WAIT) && (state_nxt != state || cal_ld))
                wait_tmr <= WAIT_CNT_W'(LINE_TIMEOUT - 1);
            else if ((state == CAL_WAIT || state == LINE_WAIT) && wait_tmr != '0)
                wait_tmr <= wait_tmr - 1'b1;

            if (state_nxt == SETTLE && state != SETTLE)
                settle_tmr <= (cfg_settle == '0) ? '0 : cfg_settle - 1'b1;
            else if (state == SETTLE && settle_tmr != '0)
                settle_tmr <= settle_tmr - 1'b1;
        end
    end

    assign line_en   = (state == CAL_WAIT && !line_gap) || (state == LINE_WAIT);
    assign cal_mode  = (state == CAL_WAIT);
    assign busy      = (state != IDLE) && (state != FAULT);
    assign done      = (state == DONE);
    assign motor_dir = busy && dir_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with an auto-responding timing generator model.
module tb_scan_sequencer;

    localparam int STEP_W       = 4;
    localparam int LINE_TIMEOUT = 100;

    logic        clk_160M = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0, dir = 1'b0;
    logic [15:0] num_lines = '0, settle_cycles = '0;
    logic [7:0]  cal_lines = '0, steps_per_line = '0;
    logic        resp_ld = 1'b0, inj_ld = 1'b0, resp_en = 1'b1, clr = 1'b0;
    logic        line_done;
    logic        line_en, cal_mode, motor_step, motor_dir, busy, done, error;
    logic [15:0] line_idx;

    assign line_done = resp_ld | inj_ld;

    scan_sequencer #(.STEP_W(STEP_W), .LINE_TIMEOUT(LINE_TIMEOUT)) dut (
        .clk_160M(clk_160M), .rst(rst), .start(start), .abort(abort),
        .num_lines(num_lines), .cal_lines(cal_lines), .steps_per_line(steps_per_line),
        .settle_cycles(settle_cycles), .dir(dir), .line_done(line_done),
        .line_en(line_en), .cal_mode(cal_mode), .motor_step(motor_step),
        .motor_dir(motor_dir), .line_idx(line_idx), .busy(busy), .done(done), .error(error)
    );

    always #5 clk_160M = ~clk_160M;

    int cyc = 0;
    always @(posedge clk_160M) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int step_rises, step_hi_bad, step_lo4, dir_bad, en_cycles, cal_rises, img_rises;
    int done_cnt, done_cyc, last_ld_cyc, first_rise_cyc, n_gaps;
    int gaps[8];
    int hi_run, lo_run, en_lo_run, resp_cnt;
    logic step_p, en_p, seen_fall;

    // Monitor plus line_done responder: pulse line_done 50 cycles after each line_en rise.
    always @(negedge clk_160M) begin
        if (clr) begin
            step_rises = 0; step_hi_bad = 0; step_lo4 = 0; dir_bad = 0; en_cycles = 0;
            cal_rises = 0; img_rises = 0; done_cnt = 0; done_cyc = -1; last_ld_cyc = -1;
            first_rise_cyc = -1; n_gaps = 0; hi_run = 0; lo_run = 1000; en_lo_run = 0;
            resp_cnt = 0; resp_ld = 1'b0; seen_fall = 1'b0;
            step_p = motor_step; en_p = line_en;
        end else begin
            if (resp_ld) resp_ld = 1'b0;
            else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    resp_ld = 1'b1;
                    last_ld_cyc = cyc;
                end
            end
            if (motor_step) begin
                if (!step_p) begin
                    step_rises++;
                    if (lo_run == STEP_W) step_lo4++;
                    hi_run = 0;
                end
                hi_run++;
                if (!motor_dir) dir_bad++;
            end else begin
                if (step_p) begin
                    if (hi_run != STEP_W) step_hi_bad++;
                    lo_run = 0;
                end
                lo_run++;
            end
            if (line_en) begin
                en_cycles++;
                if (!en_p) begin
                    if (cal_mode) cal_rises++; else img_rises++;
                    if (first_rise_cyc < 0) first_rise_cyc = cyc;
                    if (seen_fall && n_gaps < 8) begin
                        gaps[n_gaps] = en_lo_run;
                        n_gaps++;
                    end
                    if (resp_en) resp_cnt = 50;
                end
            end else begin
                if (en_p) begin
                    seen_fall = 1'b1;
                    en_lo_run = 0;
                end
                en_lo_run++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            step_p = motor_step;
            en_p = line_en;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_160M);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic set_cfg(input int c, input int n, input int s, input int st, input logic d);
        cal_lines = 8'(c); num_lines = 16'(n); steps_per_line = 8'(s);
        settle_cycles = 16'(st); dir = d;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            tick();
            i++;
        end
        check_val(tag, done, 1);
    endtask

    initial begin
        int cs, i;
        tick(3);
        check_val("reset_outputs", {busy, line_en, cal_mode, motor_step, motor_dir, done, error}, 0);
        check_val("reset_line_idx", line_idx, 0);
        rst = 1'b0;
        tick();

        // full frame: 2 cal lines, 3 image lines of 4 steps + 10 settle
        set_cfg(2, 3, 4, 10, 1'b1);
        clear_stats();
        pulse_start();
        check_val("t1_first_cycle", {busy, line_en, cal_mode, motor_dir}, 4'b1111);
        wait_done("t1_done_seen", 3000);
        tick();
        check_val("t1_busy_off", busy, 0);
        tick(3);
        check_val("t1_done_cnt", done_cnt, 1);
        check_val("t1_done_latency", done_cyc - last_ld_cyc, 1);
        check_val("t1_line_idx", line_idx, 3);
        check_val("t1_cal_rises", cal_rises, 2);
        check_val("t1_img_rises", img_rises, 3);
        check_val("t1_step_pulses", step_rises, 12);
        check_val("t1_step_hi_bad", step_hi_bad, 0);
        check_val("t1_step_lo_inner", step_lo4, 9);
        check_val("t1_dir_bad", dir_bad, 0);
        check_val("t1_n_gaps", n_gaps, 4);
        check_val("t1_gap_cal", gaps[0], 1);
        for (int g = 1; g < 4; g++) check_val($sformatf("t1_gap_%0d", g), gaps[g], 42);

        // empty frame
        set_cfg(0, 0, 0, 0, 1'b0);
        clear_stats();
        pulse_start();
        check_val("t2_k1", {busy, done}, 2'b10);
        tick();
        check_val("t2_k2", {busy, done}, 2'b11);
        tick();
        check_val("t2_k3", {busy, done}, 2'b00);
        check_val("t2_no_line_en", en_cycles, 0);
        check_val("t2_done_cnt", done_cnt, 1);

        // back-to-back lines without steps or settle
        set_cfg(0, 2, 0, 0, 1'b0);
        clear_stats();
        pulse_start();
        check_val("t3_k1_line_en", {line_en, cal_mode}, 2'b10);
        wait_done("t3_done_seen", 500);
        tick(2);
        check_val("t3_n_gaps", n_gaps, 1);
        check_val("t3_gap", gaps[0], 1);
        check_val("t3_img_rises", img_rises, 2);
        check_val("t3_line_idx", line_idx, 2);

        // abort during the third step of line 1
        set_cfg(0, 3, 4, 10, 1'b0);
        clear_stats();
        pulse_start();
        i = 0;
        while (step_rises < 7 && i < 1000) begin
            tick();
            i++;
        end
        check_val("t4_reach_step", step_rises, 7);
        check_val("t4_idx_before", line_idx, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t4_after_abort", {motor_step, busy, line_en, motor_dir}, 0);
        tick(80);
        check_val("t4_no_done", done_cnt, 0);
        check_val("t4_line_idx", line_idx, 1);
        check_val("t4_no_more_steps", step_rises, 7);

        // timeout
        resp_en = 1'b0;
        set_cfg(0, 1, 0, 0, 1'b0);
        clear_stats();
        pulse_start();
        tick(99);
        check_val("t5_last_wait", {line_en, error}, 2'b10);
        tick();
        check_val("t5_fault", {error, line_en, busy}, 3'b100);
        tick();
        check_val("t5_idle_err", {error, busy}, 2'b10);
        tick(10);
        check_val("t5_sticky", error, 1);
        check_val("t5_wait_len", en_cycles, 100);
        check_val("t5_no_done", done_cnt, 0);
        resp_en = 1'b1;
        clear_stats();
        pulse_start();
        check_val("t5_cleared", error, 0);
        wait_done("t5_done_seen", 500);
        tick();
        check_val("t5_line_idx", line_idx, 1);

        // start while busy and line_done during SETTLE are ignored
        set_cfg(0, 2, 1, 20, 1'b0);
        clear_stats();
        pulse_start();
        cs = cyc;
        tick(2);
        pulse_start();
        check_val("t6_busy", busy, 1);
        tick(7);
        inj_ld = 1'b1;
        tick();
        inj_ld = 1'b0;
        check_val("t6_ld_in_settle", {line_en, 16'(line_idx)}, 0);
        wait_done("t6_done_seen", 1000);
        tick(2);
        check_val("t6_first_rise", first_rise_cyc - cs, 28);
        check_val("t6_gap", gaps[0], 28);
        check_val("t6_steps", step_rises, 2);
        check_val("t6_img_rises", img_rises, 2);
        check_val("t6_done_cnt", done_cnt, 1);
        check_val("t6_line_idx", line_idx, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
